// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor on refclk: pulses pll_rst, qualifies lock, releases sys_rst, retries then faults.
// Optional: define PLL_LOSS_COUNT_EN to add the saturating loss_count output.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int RETRY_W             = $clog2(MAX_RETRIES + 1)
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
`ifdef PLL_LOSS_COUNT_EN
    output logic [7:0]         loss_count,
`endif
    output logic [RETRY_W-1:0] retry_count
);

    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [RETRY_W-1:0]   r_retry;
    logic [RETRY_W-1:0]   w_retry_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_lock_s;
    logic                 w_loss_event;
    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_ready;
    logic                 r_fault;

    assign w_lock_s = r_sync2;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_retry_next = r_retry;
        w_loss_event = 1'b0;
        case (r_state)
            ST_RESET: begin
                if (r_cnt == PULSE_LAST) w_next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (relock_req) begin
                    w_next_state = ST_RESET;
                    w_retry_next = '0;
                end else if (w_lock_s) begin
                    w_next_state = ST_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_retry_next = r_retry + 1'b1;
                    w_next_state = (r_retry == RETRY_LAST) ? ST_FAULT : ST_RESET;
                end
            end
            ST_STABLE: begin
                if (relock_req) begin
                    w_next_state = ST_RESET;
                    w_retry_next = '0;
                end else if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_next_state = ST_RUN;
                    w_retry_next = '0;
                end
            end
            ST_RUN: begin
                if (relock_req) begin
                    w_next_state = ST_RESET;
                    w_retry_next = '0;
                end else if (!w_lock_s) begin
                    w_next_state = ST_RESET;
                    w_loss_event = 1'b1;
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    w_next_state = ST_RESET;
                    w_retry_next = '0;
                end
            end
            default: begin
                w_next_state = ST_RESET;
                w_retry_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as r_state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RESET;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_retry   <= w_retry_next;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_RESET || r_state == ST_WAIT_LOCK || r_state == ST_STABLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_pll_rst <= (w_next_state == ST_RESET) || (w_next_state == ST_FAULT);
            r_sys_rst <= (w_next_state != ST_RUN);
            r_ready   <= (w_next_state == ST_RUN);
            r_fault   <= (w_next_state == ST_FAULT);
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= '0;
        end else if (w_loss_event && r_loss_cnt != 8'hFF) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign loss_count = r_loss_cnt;
`endif

    assign pll_rst     = r_pll_rst;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;

endmodule
